// File: rtl/alarm_controller_if.sv
// Signal bundle between the time-of-day/button front end and the alarm controller.
// The controller takes the slave side; the front end or testbench takes the master side.
interface alarm_controller_if;
   logic [3:0] t_min;
   logic [3:0] t_minten;
   logic [3:0] t_hour;
   logic [3:0] t_hourten;
   logic       alarm_en;
   logic       set_mode;
   logic       inc_hour;
   logic       inc_min;
   logic       snooze;
   logic       stop;
   logic [3:0] al_min;
   logic [3:0] al_minten;
   logic [3:0] al_hour;
   logic [3:0] al_hourten;
   logic       ringing;
   logic       snoozing;
   logic       buzzer;

   modport master (
      output t_min, t_minten, t_hour, t_hourten,
      output alarm_en, set_mode, inc_hour, inc_min, snooze, stop,
      input  al_min, al_minten, al_hour, al_hourten,
      input  ringing, snoozing, buzzer
   );

   modport slave (
      input  t_min, t_minten, t_hour, t_hourten,
      input  alarm_en, set_mode, inc_hour, inc_min, snooze, stop,
      output al_min, al_minten, al_hour, al_hourten,
      output ringing, snoozing, buzzer
   );
endinterface

// File: rtl/alarm_controller.sv
// Alarm setpoint, time-match detection, ring/snooze state machine and buzzer tone
// generator, fed by the 12-hour BCD time-of-day counter.
module alarm_controller #(
   parameter int TONE_DIV   = 25000,
   parameter int RING_MIN   = 5,
   parameter int SNOOZE_MIN = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   alarm_controller_if.slave  bus
);

   localparam int RW = (RING_MIN   > 1) ? $clog2(RING_MIN)   : 1;
   localparam int SW = (SNOOZE_MIN > 1) ? $clog2(SNOOZE_MIN) : 1;
   localparam int TW = (TONE_DIV   > 1) ? $clog2(TONE_DIV)   : 1;
   localparam logic [RW-1:0] RING_LAST   = RW'(RING_MIN - 1);
   localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_MIN - 1);
   localparam logic [TW-1:0] TONE_LAST   = TW'(TONE_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } state_t;

   state_t        state;
   logic [15:0]   r1, r2, s;
   logic          min_evt;
   logic          match;
   logic [3:0]    al_min, al_minten, al_hour, al_hourten;
   logic [15:0]   setpoint;
   logic [RW-1:0] ring_cnt;
   logic [SW-1:0] snz_cnt;
   logic [TW-1:0] tone_cnt;
   logic          ringing_q, snoozing_q, buzzer_q;

   assign setpoint = {al_hourten, al_hour, al_minten, al_min};

   // Time digits come from an unrelated slow domain: accept a value only once it has
   // been seen unchanged on two consecutive samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1 <= 16'h0000;
         r2 <= 16'h0000;
         s  <= 16'h0000;
      end else begin
         // NOTE: non-blocking so r2 takes the old r1; blocking would collapse the pipeline.
         r1 <= {bus.t_hourten, bus.t_hour, bus.t_minten, bus.t_min};
         r2 <= r1;
         if (min_evt) s <= r2;
      end
   end

   // NOTE: min_evt is combinational so match compares the value S is loading this cycle.
   assign min_evt = (r1 == r2) && (r2 != s);
   assign match   = min_evt && (r2 == setpoint) && bus.alarm_en && !bus.set_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         al_hourten <= 4'd0;
         al_hour    <= 4'd6;
         al_minten  <= 4'd0;
         al_min     <= 4'd0;
      end else if (bus.set_mode) begin
         if (bus.inc_hour) begin
            if (al_hourten == 4'd1 && al_hour == 4'd2) begin
               al_hourten <= 4'd0;
               al_hour    <= 4'd1;
            end else if (al_hour == 4'd9) begin
               al_hourten <= 4'd1;
               al_hour    <= 4'd0;
            end else begin
               al_hour <= al_hour + 4'd1;
            end
         end
         // Minute wraps 59 -> 00 without touching the hour.
         if (bus.inc_min) begin
            if (al_min == 4'd9) begin
               al_min    <= 4'd0;
               al_minten <= (al_minten == 4'd5) ? 4'd0 : al_minten + 4'd1;
            end else begin
               al_min <= al_min + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ring_cnt   <= '0;
         snz_cnt    <= '0;
         tone_cnt   <= '0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
         buzzer_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               buzzer_q <= 1'b0;
               if (match) begin
                  state     <= RING;
                  ringing_q <= 1'b1;
                  ring_cnt  <= '0;
                  tone_cnt  <= '0;
               end
            end
            RING: begin
               if (!bus.alarm_en || bus.set_mode || bus.stop) begin
                  state     <= IDLE;
                  ringing_q <= 1'b0;
                  buzzer_q  <= 1'b0;
               end else if (bus.snooze) begin
                  state      <= SNOOZE;
                  ringing_q  <= 1'b0;
                  snoozing_q <= 1'b1;
                  snz_cnt    <= '0;
                  buzzer_q   <= 1'b0;
               end else if (min_evt && ring_cnt == RING_LAST) begin
                  state     <= IDLE;
                  ringing_q <= 1'b0;
                  buzzer_q  <= 1'b0;
               end else begin
                  if (min_evt) ring_cnt <= ring_cnt + 1'b1;
                  if (tone_cnt == TONE_LAST) begin
                     tone_cnt <= '0;
                     buzzer_q <= ~buzzer_q;
                  end else begin
                     tone_cnt <= tone_cnt + 1'b1;
                  end
               end
            end
            SNOOZE: begin
               buzzer_q <= 1'b0;
               if (!bus.alarm_en || bus.set_mode || bus.stop) begin
                  state      <= IDLE;
                  snoozing_q <= 1'b0;
               end else if (min_evt) begin
                  if (snz_cnt == SNOOZE_LAST) begin
                     state      <= RING;
                     snoozing_q <= 1'b0;
                     ringing_q  <= 1'b1;
                     ring_cnt   <= '0;
                     tone_cnt   <= '0;
                  end else begin
                     snz_cnt <= snz_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               ringing_q  <= 1'b0;
               snoozing_q <= 1'b0;
               buzzer_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.al_min     = al_min;
   assign bus.al_minten  = al_minten;
   assign bus.al_hour    = al_hour;
   assign bus.al_hourten = al_hourten;
   assign bus.ringing    = ringing_q;
   assign bus.snoozing   = snoozing_q;
   assign bus.buzzer     = buzzer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus randomized
// ring/snooze/stop traffic compared against a minute-level behavioural model.
module tb_alarm_controller;

   localparam int TONE_DIV   = 4;
   localparam int RING_MIN   = 5;
   localparam int SNOOZE_MIN = 9;
   localparam int HOLD       = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   alarm_controller_if bus ();

   alarm_controller #(
      .TONE_DIV  (TONE_DIV),
      .RING_MIN  (RING_MIN),
      .SNOOZE_MIN(SNOOZE_MIN)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int evt_cnt  = 0;

   always @(posedge clk) if (dut.min_evt) evt_cnt <= evt_cnt + 1;

   // Model: 0 idle, 1 ringing, 2 snoozing; m_n counts minutes since entering the state.
   int m_state, m_n;
   int sp_h, sp_m;
   int cur_h, cur_m;

   function automatic logic [15:0] bcd(input int h, input int m);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   function automatic void model_minute(input int h, input int m);
      if (m_state == 0) begin
         if (bus.alarm_en && !bus.set_mode && h == sp_h && m == sp_m) begin
            m_state = 1;
            m_n     = 0;
         end
      end else if (m_state == 1) begin
         m_n++;
         if (m_n >= RING_MIN) m_state = 0;
      end else begin
         m_n++;
         if (m_n >= SNOOZE_MIN) begin
            m_state = 1;
            m_n     = 0;
         end
      end
   endfunction

   function automatic void model_button(input logic st, input logic sn);
      if (st) m_state = 0;
      else if (sn && m_state == 1) begin
         m_state = 2;
         m_n     = 0;
      end
   endfunction

   function automatic void model_edit(input logic ih, input logic im);
      if (bus.set_mode) begin
         if (ih) sp_h = (sp_h % 12) + 1;
         if (im) sp_m = (sp_m + 1) % 60;
      end
   endfunction

   task automatic drive_digits(input int h, input int m);
      {bus.t_hourten, bus.t_hour, bus.t_minten, bus.t_min} = bcd(h, m);
   endtask

   task automatic step_time(input int h, input int m);
      bit changed;
      @(negedge clk);
      changed = (h != cur_h) || (m != cur_m);
      drive_digits(h, m);
      cur_h = h;
      cur_m = m;
      repeat (HOLD) @(negedge clk);
      if (changed) model_minute(h, m);
   endtask

   task automatic pulse(input logic st, input logic sn, input logic ih, input logic im);
      @(negedge clk);
      bus.stop = st; bus.snooze = sn; bus.inc_hour = ih; bus.inc_min = im;
      @(negedge clk);
      bus.stop = 1'b0; bus.snooze = 1'b0; bus.inc_hour = 1'b0; bus.inc_min = 1'b0;
   endtask

   task automatic test_reset();
      int base;
      bus.alarm_en = 1'b0; bus.set_mode = 1'b0;
      bus.stop = 1'b0; bus.snooze = 1'b0; bus.inc_hour = 1'b0; bus.inc_min = 1'b0;
      drive_digits(5, 59);
      cur_h = 5; cur_m = 59; sp_h = 6; sp_m = 0; m_state = 0; m_n = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      base = evt_cnt;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if ({bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min} !== 16'h0600)
         $display("FAIL reset_setpoint: got %h expected 0600",
                  {bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min});
      else n_pass++;
      n_checks++;
      if ({bus.ringing, bus.snoozing, bus.buzzer} !== 3'b000)
         $display("FAIL reset_outputs: got %b expected 000", {bus.ringing, bus.snoozing, bus.buzzer});
      else n_pass++;
      n_checks++;
      if (evt_cnt - base !== 1)
         $display("FAIL reset_min_evt: got %0d events expected 1", evt_cnt - base);
      else n_pass++;
   endtask

   task automatic test_ring_tone();
      bit found = 0;
      int lat = 0;
      logic exp_bz;
      bus.alarm_en = 1'b1;
      @(negedge clk);
      drive_digits(6, 0);
      cur_h = 6; cur_m = 0;
      model_minute(6, 0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (bus.ringing) begin
            found = 1;
            lat = i;
            break;
         end
      end
      n_checks++;
      if (!found) $display("FAIL ring_latency: ringing not seen within 4 clk (got %0d)", lat);
      else n_pass++;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge clk);
         exp_bz = ((c / TONE_DIV) % 2) != 0;
         n_checks++;
         if (bus.buzzer !== exp_bz)
            $display("FAIL tone_c%0d: buzzer %b expected %b", c, bus.buzzer, exp_bz);
         else n_pass++;
      end
   endtask

   task automatic test_snooze();
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      model_button(1'b0, 1'b1);
      for (int k = 0; k <= 9; k++) begin
         if (k > 0) step_time(6, k);
         n_checks++;
         if ({bus.ringing, bus.snoozing, bus.buzzer & ~bus.ringing} !==
             {m_state == 1, m_state == 2, 1'b0})
            $display("FAIL snooze_step%0d: r/s/bz %b expected %b", k,
                     {bus.ringing, bus.snoozing, bus.buzzer & ~bus.ringing},
                     {m_state == 1, m_state == 2, 1'b0});
         else n_pass++;
      end
   endtask

   task automatic test_ring_timeout();
      for (int k = 10; k <= 14; k++) begin
         step_time(6, k);
         n_checks++;
         if ({bus.ringing, bus.snoozing, bus.buzzer} !== {m_state == 1, m_state == 2, bus.ringing & bus.buzzer})
            $display("FAIL timeout_step%0d: r/s/bz %b expected ring=%0d snz=%0d", k,
                     {bus.ringing, bus.snoozing, bus.buzzer}, m_state == 1, m_state == 2);
         else n_pass++;
      end
      step_time(6, 0);
      n_checks++;
      if (bus.ringing !== 1'b1) $display("FAIL retrigger: ringing %b expected 1", bus.ringing);
      else n_pass++;
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      model_button(1'b1, 1'b1);
      n_checks++;
      if ({bus.ringing, bus.snoozing, bus.buzzer} !== 3'b000)
         $display("FAIL stop_beats_snooze: r/s/bz %b expected 000", {bus.ringing, bus.snoozing, bus.buzzer});
      else n_pass++;
   endtask

   task automatic test_edit();
      logic ih, im;
      bus.set_mode = 1'b1;
      for (int i = 0; i < 7; i++) begin pulse(1'b0, 1'b0, 1'b1, 1'b0); model_edit(1'b1, 1'b0); end
      for (int i = 0; i < 61; i++) begin pulse(1'b0, 1'b0, 1'b0, 1'b1); model_edit(1'b0, 1'b1); end
      n_checks++;
      if ({bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min} !== 16'h0101)
         $display("FAIL edit_wrap: got %h expected 0101",
                  {bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min});
      else n_pass++;
      bus.set_mode = 1'b0;
      for (int i = 0; i < 10; i++) begin pulse(1'b0, 1'b0, 1'b1, 1'b1); model_edit(1'b1, 1'b1); end
      n_checks++;
      if ({bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min} !== bcd(sp_h, sp_m))
         $display("FAIL edit_locked: got %h expected %h",
                  {bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min}, bcd(sp_h, sp_m));
      else n_pass++;
      bus.set_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ih = 1'($urandom_range(0, 1));
         im = 1'($urandom_range(0, 1));
         pulse(1'b0, 1'b0, ih, im);
         model_edit(ih, im);
      end
      n_checks++;
      if ({bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min} !== bcd(sp_h, sp_m))
         $display("FAIL edit_random: got %h expected %h",
                  {bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min}, bcd(sp_h, sp_m));
      else n_pass++;
      @(negedge clk);
      bus.set_mode = 1'b0;
   endtask

   task automatic test_glitch();
      int base;
      @(negedge clk);
      base = evt_cnt;
      drive_digits(sp_h, sp_m);
      @(negedge clk);
      drive_digits(cur_h, cur_m);
      repeat (6) @(negedge clk);
      n_checks++;
      if (evt_cnt - base !== 0 || bus.ringing !== 1'b0)
         $display("FAIL glitch: events %0d ringing %b expected 0 and 0", evt_cnt - base, bus.ringing);
      else n_pass++;
   endtask

   task automatic test_random_ring();
      int op, nh, nm;
      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 3));
         case (op)
            0: begin
               nm = (cur_m + 1) % 60;
               nh = (nm == 0) ? (cur_h % 12) + 1 : cur_h;
               step_time(nh, nm);
            end
            1: step_time(sp_h, sp_m);
            2: begin pulse(1'b0, 1'b1, 1'b0, 1'b0); model_button(1'b0, 1'b1); end
            default: begin pulse(1'b1, 1'b0, 1'b0, 1'b0); model_button(1'b1, 1'b0); end
         endcase
         n_checks++;
         if ({bus.ringing, bus.snoozing, bus.buzzer & ~bus.ringing} !==
             {m_state == 1, m_state == 2, 1'b0})
            $display("FAIL random_step%0d op%0d: r/s/bz %b expected %b", i, op,
                     {bus.ringing, bus.snoozing, bus.buzzer & ~bus.ringing},
                     {m_state == 1, m_state == 2, 1'b0});
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      int nm, nh;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      model_button(1'b1, 1'b0);
      nm = (sp_m + 1) % 60;
      nh = (nm == 0) ? (sp_h % 12) + 1 : sp_h;
      step_time(nh, nm);
      step_time(sp_h, sp_m);
      for (int i = 0; i < 8 && bus.buzzer !== 1'b1; i++) @(negedge clk);
      n_checks++;
      if ({bus.ringing, bus.buzzer} !== 2'b11)
         $display("FAIL pre_reset_ring: ring/bz %b expected 11", {bus.ringing, bus.buzzer});
      else n_pass++;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.ringing, bus.snoozing, bus.buzzer} !== 3'b000 ||
          {bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min} !== 16'h0600)
         $display("FAIL async_reset: r/s/bz %b setpoint %h expected 000 0600",
                  {bus.ringing, bus.snoozing, bus.buzzer},
                  {bus.al_hourten, bus.al_hour, bus.al_minten, bus.al_min});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_ring_tone();
      test_snooze();
      test_ring_timeout();
      test_edit();
      test_glitch();
      test_random_ring();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
